// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode pipeline buffers: default sizes,
// the NOP instruction word and the fetch bundle layout.
package pipe_pkg;

    localparam int PC_SIZE_DEF   = 18;
    localparam int DATA_SIZE_DEF = 32;
    localparam int LANES_DEF     = 2;
    localparam int CNT_W_DEF     = 16;

    localparam logic [31:0] NOP_IR = 32'h0;

    // Field order matches the flat packing used inside if_id_pipe_buf.
    typedef struct packed {
        logic [PC_SIZE_DEF-1:0]           pc;
        logic [LANES_DEF*DATA_SIZE_DEF-1:0] ir;
        logic [LANES_DEF-1:0]             lane_valid;
    } bundle_t;

    function automatic int bundle_width(input int pc_size, input int data_size, input int lanes);
        return pc_size + lanes * (data_size + 1);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready buffer with flush. in_ready depends only on
// registered occupancy, so the producer never waits combinationally on the consumer.
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] mem [2];
    logic             head;
    logic [1:0]       count;
    logic             tail;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2) && rst;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign tail      = head ^ count[0];
    assign out_data  = mem[head];
    assign occupancy = count;

    // Flush and reset both empty the buffer; head restarts at slot 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= 1'b0;
            count <= 2'd0;
        end else if (flush) begin
            head  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (pop)
                head <= ~head;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= in_data;
    end

endmodule

// File: rtl/if_id_pipe_buf.sv
// IF/ID stage register: buffers multi-lane fetch bundles in a 2-entry skid
// buffer, presents a NOP bundle when empty and counts decode stall cycles.
module if_id_pipe_buf
    import pipe_pkg::*;
#(
    parameter int PC_SIZE   = PC_SIZE_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int LANES     = LANES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_SIZE-1:0]         in_pc,
    input  logic [LANES*DATA_SIZE-1:0] in_ir,
    input  logic [LANES-1:0]           in_lane_valid,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_SIZE-1:0]         out_pc,
    output logic [LANES*DATA_SIZE-1:0] out_ir,
    output logic [LANES-1:0]           out_lane_valid,
    output logic [1:0]                 occupancy,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int WIDTH = bundle_width(PC_SIZE, DATA_SIZE, LANES);

    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] head_data;
    logic             buf_valid;

    assign in_data = {in_pc, in_ir, in_lane_valid};

    pipe_skid_buf #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(buf_valid),
        .out_ready(out_ready),
        .out_data (head_data),
        .occupancy(occupancy)
    );

    assign out_valid = buf_valid;

    // An empty buffer shows a NOP bundle instead of whatever the slot last held.
    always_comb begin
        out_pc         = '0;
        out_ir         = {LANES{DATA_SIZE'(NOP_IR)}};
        out_lane_valid = '0;
        if (buf_valid) begin
            out_pc         = head_data[WIDTH-1 -: PC_SIZE];
            out_ir         = head_data[LANES +: LANES*DATA_SIZE];
            out_lane_valid = head_data[LANES-1:0];
        end
    end

    // Stall cycles keep counting through a flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst)
            stall_cnt <= '0;
        else if (buf_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule
